// File: rtl/uart_rx.sv
// UART receiver: deserialises 8N1 frames from an asynchronous line into bytes on a
// valid/ready interface, with 3-sample majority voting, framing-error and overrun flags.
module uart_rx #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned HALF         = CLKS_PER_BIT / 2;
   localparam int unsigned CW           = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] CNT_SAMP_A = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_SAMP_B = CW'(HALF);
   localparam logic [CW-1:0] CNT_MID    = CW'(HALF + 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);

   // Fewer than 8 clocks per bit leaves no room for three distinct mid-bit samples.
   if (CLKS_PER_BIT < 8) begin : g_bad_cfg
      $error("uart_rx: CLK_FREQ / BAUD must be at least 8");
   end

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } state_e;

   // Synchroniser and edge-detect history
   logic rx_meta;
   logic rx_s;
   logic rx_prev;

   // Bit-timing state
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          samp_a_q, samp_a_d;
   logic          samp_b_q, samp_b_d;

   // Per-cycle events from the FSM
   logic maj;
   logic at_mid;
   logic at_last;
   logic deliver;
   logic ferr;

   // Two-flop synchroniser on the raw line, plus one more flop for falling-edge detection
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // FSM and bit-timing registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         samp_a_q  <= 1'b1;
         samp_b_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         samp_a_q  <= samp_a_d;
         samp_b_q  <= samp_b_d;
      end
   end

   // Third vote is the live synchronised line at HALF+1, so the decision needs no extra cycle.
   assign maj     = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);
   assign at_mid  = (cnt_q == CNT_MID);
   assign at_last = (cnt_q == CNT_LAST);

   // Next-state logic: bit counting, majority capture, shifting and frame decisions
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      samp_a_d  = (cnt_q == CNT_SAMP_A) ? rx_s : samp_a_q;
      samp_b_d  = (cnt_q == CNT_SAMP_B) ? rx_s : samp_b_q;
      deliver   = 1'b0;
      ferr      = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (rx_prev && !rx_s) begin
               state_d = StStart;
            end
         end

         StStart: begin
            if (at_mid && maj) begin
               // Glitch rather than a real start bit
               state_d = StIdle;
               cnt_d   = '0;
            end else if (at_last) begin
               state_d   = StData;
               cnt_d     = '0;
               bit_idx_d = '0;
            end
         end

         StData: begin
            if (at_mid) begin
               shreg_d = {maj, shreg_q[7:1]};
            end
            if (at_last) begin
               cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end

         StStop: begin
            // Leave mid-stop-bit so a following start edge is never missed.
            if (at_mid) begin
               cnt_d = '0;
               if (maj) begin
                  deliver = 1'b1;
                  state_d = StIdle;
               end else begin
                  ferr    = 1'b1;
                  state_d = StBreak;
               end
            end
         end

         StBreak: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Output holding register: delivery, handshake consumption, overrun and frame-error pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr;
         if (deliver) begin
            // A byte being accepted this cycle frees the slot for the new one.
            if (!rx_valid || rx_ready) begin
               rx_data  <= shreg_q;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   // Monitor state (written only by the monitor process)
   int         cyc      = 0;
   int         n_vcyc   = 0;
   int         n_rise   = 0;
   int         rise_cyc = 0;
   int         n_ferr   = 0;
   int         ferr_cyc = 0;
   int         n_acc    = 0;
   logic [7:0] acc_log [64];
   logic       prev_v   = 1'b0;

   // Stimulus bookkeeping (written only by the stimulus process)
   int t0;

   uart_rx #(
      .CLK_FREQ(1_000_000),
      .BAUD    (100_000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records handshakes, valid rises and frame-error pulses on the falling edge
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rx_valid) n_vcyc = n_vcyc + 1;
      if (rx_valid && !prev_v) begin
         n_rise   = n_rise + 1;
         rise_cyc = cyc;
      end
      prev_v = rx_valid;
      if (frame_err) begin
         n_ferr   = n_ferr + 1;
         ferr_cyc = cyc;
      end
      if (rx_valid && rx_ready) begin
         if (n_acc < 64) acc_log[n_acc] = rx_data;
         n_acc = n_acc + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int obs, input int lo, input int hi);
      n_checks++;
      assert (obs >= lo && obs <= hi) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_level(input logic v, input int n);
      rx = v;
      tick(n);
   endtask

   // One 8N1 frame; glitch_bit >= 0 flips that data bit for the single cycle hitting cnt=HALF.
   task automatic send_byte(input logic [7:0] b, input logic stop_val, input int glitch_bit);
      t0 = cyc;
      drive_level(1'b0, 10);
      for (int i = 0; i < 8; i++) begin
         if (i == glitch_bit) begin
            drive_level(b[i], 6);
            drive_level(~b[i], 1);
            drive_level(b[i], 3);
         end else begin
            drive_level(b[i], 10);
         end
      end
      drive_level(stop_val, 10);
   endtask

   initial begin
      int base_acc;
      int base_ferr;
      int base_vcyc;
      int base_rise;
      int n;
      logic [7:0] b;

      rst_n    = 1'b0;
      rx       = 1'b1;
      rx_ready = 1'b1;
      tick(5);
      rst_n = 1'b1;
      tick(2);

      // Reset state
      check("rst_rx_data", {24'd0, rx_data}, 32'h0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'h0);
      check("rst_frame_err", {31'd0, frame_err}, 32'h0);
      check("rst_overrun", {31'd0, overrun}, 32'h0);
      check("rst_busy", {31'd0, busy}, 32'h0);
      tick(20);

      // Single byte with latency and one-cycle valid
      base_acc  = n_acc;
      base_ferr = n_ferr;
      base_vcyc = n_vcyc;
      base_rise = n_rise;
      send_byte(8'hA5, 1'b1, -1);
      tick(20);
      check("single_count", n_acc - base_acc, 1);
      check("single_data", {24'd0, acc_log[base_acc]}, 32'hA5);
      check("single_rise_count", n_rise - base_rise, 1);
      check_range("single_latency", rise_cyc - t0, 100, 102);
      check("single_valid_cycles", n_vcyc - base_vcyc, 1);
      check("single_ferr", n_ferr - base_ferr, 0);
      check("single_overrun", {31'd0, overrun}, 32'h0);

      // Back-to-back frames, glitch in bit 3 of the last one
      base_acc  = n_acc;
      base_ferr = n_ferr;
      send_byte(8'h00, 1'b1, -1);
      send_byte(8'hFF, 1'b1, -1);
      send_byte(8'h55, 1'b1, 3);
      tick(20);
      check("b2b_count", n_acc - base_acc, 3);
      check("b2b_byte0", {24'd0, acc_log[base_acc]}, 32'h00);
      check("b2b_byte1", {24'd0, acc_log[base_acc + 1]}, 32'hFF);
      check("b2b_byte2", {24'd0, acc_log[base_acc + 2]}, 32'h55);
      check("b2b_ferr", n_ferr - base_ferr, 0);

      // False start: 3-cycle low pulse
      base_acc  = n_acc;
      base_ferr = n_ferr;
      drive_level(1'b0, 3);
      rx = 1'b1;
      @(negedge clk);
      check("false_busy_high", {31'd0, busy}, 32'h1);
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_range("false_busy_drop", n, 0, 8);
      check("false_busy_low", {31'd0, busy}, 32'h0);
      tick(30);
      check("false_no_valid", n_acc - base_acc, 0);
      check("false_no_ferr", n_ferr - base_ferr, 0);

      // Framing error with line held low for 30 cycles from the stop bit
      base_acc  = n_acc;
      base_ferr = n_ferr;
      send_byte(8'h3C, 1'b0, -1);
      drive_level(1'b0, 20);
      check("ferr_busy_held", {31'd0, busy}, 32'h1);
      check("ferr_count", n_ferr - base_ferr, 1);
      check_range("ferr_latency", ferr_cyc - t0, 100, 102);
      check("ferr_no_valid", n_acc - base_acc, 0);
      drive_level(1'b1, 5);
      check("ferr_busy_released", {31'd0, busy}, 32'h0);
      tick(20);
      send_byte(8'h3C, 1'b1, -1);
      tick(20);
      check("ferr_recover_count", n_acc - base_acc, 1);
      check("ferr_recover_data", {24'd0, acc_log[base_acc]}, 32'h3C);

      // Overrun: two bytes with no consumer
      rx_ready = 1'b0;
      base_acc = n_acc;
      send_byte(8'h11, 1'b1, -1);
      tick(10);
      check("ovr_first_no_flag", {31'd0, overrun}, 32'h0);
      send_byte(8'h22, 1'b1, -1);
      tick(20);
      check("ovr_valid_held", {31'd0, rx_valid}, 32'h1);
      check("ovr_data_kept", {24'd0, rx_data}, 32'h11);
      check("ovr_flag", {31'd0, overrun}, 32'h1);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      check("ovr_valid_cleared", {31'd0, rx_valid}, 32'h0);
      check("ovr_accept_count", n_acc - base_acc, 1);
      check("ovr_accept_data", {24'd0, acc_log[base_acc]}, 32'h11);
      tick(50);
      check("ovr_sticky", {31'd0, overrun}, 32'h1);

      // Reset during bit 4 of 0x9A, then recover with 0xC3
      rx_ready = 1'b1;
      b = 8'h9A;
      drive_level(1'b0, 10);
      for (int i = 0; i < 4; i++) drive_level(b[i], 10);
      drive_level(b[4], 5);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("mid_rst_rx_data", {24'd0, rx_data}, 32'h0);
      check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'h0);
      check("mid_rst_frame_err", {31'd0, frame_err}, 32'h0);
      check("mid_rst_overrun", {31'd0, overrun}, 32'h0);
      check("mid_rst_busy", {31'd0, busy}, 32'h0);
      drive_level(b[4], 4);
      for (int i = 5; i < 8; i++) drive_level(b[i], 10);
      drive_level(1'b1, 10);
      drive_level(1'b1, 100);
      base_acc = n_acc;
      send_byte(8'hC3, 1'b1, -1);
      tick(20);
      check("mid_rst_recover_count", n_acc - base_acc, 1);
      check("mid_rst_recover_data", {24'd0, acc_log[base_acc]}, 32'hC3);
      check("mid_rst_no_overrun", {31'd0, overrun}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the PC-to-FPGA direction of the serial link, complementing the transmitter that streams ECG samples. It deserialises 8N1 frames arriving on the board `uart_rx` pin into bytes and presents them on a valid/ready interface for a downstream command decoder (MAX30003 register writes, stream start/stop). It reports framing errors and overruns.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bits per second.
- Derived: `CLKS_PER_BIT = CLK_FREQ / BAUD`, truncated; `HALF = CLKS_PER_BIT / 2`, truncated. `CLKS_PER_BIT >= 8` is required, and a smaller value is a configuration error.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  8  received byte; stable while `rx_valid` = 1.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts the byte in any cycle where `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overrun`  out  1  sticky; set when a byte is dropped because the previous byte was not accepted. Cleared only by reset.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Synchroniser:** two flops on `rx`, both reset to 1. Output `rx_s` feeds a registered `rx_prev`, also reset to 1.
- **Majority sampling:** each bit period is counted by `cnt`, running from 0 to CLKS_PER_BIT-1, with width $clog2(CLKS_PER_BIT). `rx_s` is captured at `cnt` = HALF-1, HALF and HALF+1. The bit value is the 2-of-3 majority, evaluated at `cnt` = HALF+1.
- **State machine:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: on a falling edge (`rx_prev`=1, `rx_s`=0), go to START with `cnt`=0.
  - START: if the majority is 1 at HALF+1, treat it as a false start and return to IDLE. Otherwise, at `cnt`=CLKS_PER_BIT-1 go to DATA with bit index 0.
  - DATA: run 8 bit periods. Shift each majority value in LSB-first. At the end of bit 7, go to STOP.
  - STOP: evaluate the majority at HALF+1.
    - If 1: deliver the byte and go to IDLE immediately. The early return allows back-to-back frames and tolerates about 4% baud mismatch.
    - If 0: pulse `frame_err` for one cycle, discard the byte and go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE.
- **Delivery,** at the STOP-accept cycle:
  - If `rx_valid`=0, or `rx_valid && rx_ready` in the same cycle: load `rx_data` and set `rx_valid`=1.
  - Otherwise: keep the old byte, drop the new one and set `overrun`=1.
- **Consumption:** `rx_valid` clears the cycle after `rx_valid && rx_ready`, unless a new byte loads in that same cycle.
- **Reset values:** `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, state IDLE, `cnt`=0, sync flops = 1.
- **Reset mid-frame:** the block returns to IDLE on the next cycle. The frame in flight may be lost or flagged as a framing error. After at least 10 bit-times of idle line, the next frame must be received correctly. No lockup is permitted.

## Timing
- Synchroniser latency: 2 cycles from the `rx` pin to `rx_s`.
- IDLE to START: the cycle after the edge is seen.
- START lasts CLKS_PER_BIT cycles. Each DATA bit lasts CLKS_PER_BIT cycles.
- STOP exits at `cnt`=HALF+1.
- `rx_valid` rises 9·CLKS_PER_BIT + HALF + 5 cycles after the `rx` pin falls, with ±1 cycle accepted for edge alignment.
- `frame_err` asserts on the same cycle `rx_valid` would have risen.
- `busy` rises the cycle START is entered and falls on the cycle IDLE is re-entered.
- Minimum frame-to-frame gap: a start bit may begin immediately after the nominal stop-bit period.

## Test plan
All scenarios use CLK_FREQ=1_000_000 and BAUD=100_000, giving CLKS_PER_BIT=10 and HALF=5.

- **Single byte:** drive 0xA5 as 8N1 with `rx_ready`=1 → `rx_data`=0xA5 and `rx_valid` high for exactly one cycle, within 100–102 cycles of the start edge. `frame_err`=0 and `overrun`=0.
- **Back-to-back with glitches:** send 0x00, 0xFF and 0x55 with no idle gap, adding a 1-cycle glitch at `cnt`=HALF in bit 3 of 0x55. Hold `rx_ready`=1 → three bytes 0x00, 0xFF, 0x55, in order and uncorrupted.
- **False start:** drive a 3-cycle low pulse on an idle line → state returns to IDLE. No `rx_valid`, no `frame_err`, and `busy` drops within 8 cycles.
- **Framing error:** send 0x3C with the stop bit low, holding the line low for 30 cycles → one `frame_err` pulse and no `rx_valid`. `busy` stays high until the line rises. A subsequent 0x3C is received correctly.
- **Overrun:** send 0x11 then 0x22 with `rx_ready`=0, then assert `rx_ready` → `rx_data` remains 0x11 and `overrun`=1 after the second frame. After the handshake `rx_valid`=0, and `overrun` stays 1 until `rst_n`=0.
- **Reset mid-frame:** assert `rst_n`=0 for 1 cycle during bit 4 of 0x9A → all outputs return to their reset values. After 10 idle bit-times, 0xC3 is received correctly.
